// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, data port and shared memory
// port of mem_port_arbiter.
//   master modport : requester/memory side (drives *_req, addresses, write
//                    data and mem_rdata; observes ready/rdata and mem_*).
//   slave modport  : arbiter side (the mirror image).
interface mem_port_arbiter_if;
  localparam int unsigned DW = 32;

  // Instruction-fetch port
  logic          if_req;
  logic [DW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;

  // Data-cache port
  logic          d_req;
  logic          d_we;
  logic [DW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;

  // Shared memory port
  logic          mem_en;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between an instruction
// fetch port and a data port. One access is in flight at a time; each
// access keeps the memory busy for MEM_LATENCY cycles, then the owner's
// ready pulses for one cycle (with read data captured for reads).
// Ports:
//   clk    : clock, rising edge
//   rst_b  : synchronous reset, active high
//   halted : blocks new grants (an in-flight access still completes)
//   busy   : high while an access is in flight
//   bus    : mem_port_arbiter_if.slave (fetch, data and memory ports)
// Parameter: MEM_LATENCY (1..15) memory busy cycles per access.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break ties toward the
// port not granted most recently; otherwise ties always go to data.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     halted,
  output logic                     busy,
  mem_port_arbiter_if.slave        bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY  = 2'd2;

  logic [1:0]    state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [DW-1:0] addr_q,      addr_d;
  logic [DW-1:0] wdata_q,     wdata_d;
  logic          we_q,        we_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic [DW-1:0] d_rdata_q,   d_rdata_d;
  logic          if_ready_q,  if_ready_d;
  logic          d_ready_q,   d_ready_d;
  logic          mem_en_q,    mem_en_d;
  logic          mem_we_q,    mem_we_d;
  logic [DW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q,      busy_d;

  logic          if_elig;
  logic          d_elig;
  logic          pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 0 = data granted most recently, 1 = fetch granted most recently
  logic          last_q, last_d;
`endif

  // A port whose ready is pulsing this cycle is not eligible, so a req still
  // held from the finished access is not granted a second time.
  assign if_elig = bus.if_req & ~if_ready_q;
  assign d_elig  = bus.d_req  & ~d_ready_q;

  // Winner selection when at least one port is eligible
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign pick_d = d_elig & (~if_elig | last_q);
`else
  assign pick_d = d_elig;
`endif

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (!halted && (if_elig || d_elig)) begin
          cnt_d = CW'(MEM_LATENCY - 1);
          if (pick_d) begin
            state_d = D_BUSY;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            we_d    = bus.d_we;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d  = 1'b0;
`endif
          end else begin
            state_d = IF_BUSY;
            addr_d  = bus.if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d  = 1'b1;
`endif
          end
        end
      end
      IF_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if_rdata_d = bus.mem_rdata;
          if_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      D_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (!we_q) d_rdata_d = bus.mem_rdata;
          d_ready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory port outputs follow the state being entered, so they are plain
    // registers yet line up with the BUSY cycles.
    busy_d      = (state_d != IDLE);
    mem_en_d    = busy_d;
    mem_we_d    = (state_d == D_BUSY) & we_d;
    mem_addr_d  = busy_d ? addr_d  : '0;
    mem_wdata_d = busy_d ? wdata_d : '0;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test of mem_port_arbiter with hand-computed
// expectations. Instance a uses MEM_LATENCY=4, instance b MEM_LATENCY=1.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_b;
  logic halted;
  logic busy_a;
  logic busy_b;

  int n_checks;
  int n_fail;

  mem_port_arbiter_if ifa ();
  mem_port_arbiter_if ifb ();

  mem_port_arbiter #(.MEM_LATENCY(4)) u_dut_a (
    .clk    (clk),
    .rst_b  (rst_b),
    .halted (halted),
    .busy   (busy_a),
    .bus    (ifa)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) u_dut_b (
    .clk    (clk),
    .rst_b  (rst_b),
    .halted (halted),
    .busy   (busy_b),
    .bus    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int en_cnt;
  int we_cnt;
  int idle_cnt;
  int rdy_cnt;
  int rdy_at;
  int nev;
  int ev_cyc[8];
  int ev_port[8];   // 0 = data, 1 = fetch
  int first_port;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_b    = 1'b1;
    halted   = 1'b0;
    ifa.if_req = 1'b0; ifa.if_addr = '0; ifa.d_req = 1'b0; ifa.d_we = 1'b0;
    ifa.d_addr = '0;   ifa.d_wdata = '0; ifa.mem_rdata = '0;
    ifb.if_req = 1'b0; ifb.if_addr = '0; ifb.d_req = 1'b0; ifb.d_we = 1'b0;
    ifb.d_addr = '0;   ifb.d_wdata = '0; ifb.mem_rdata = '0;

    repeat (3) @(negedge clk);
    rst_b = 1'b0;

    // Reset state
    check_eq("rst_mem_en",  32'(ifa.mem_en),   32'd0);
    check_eq("rst_busy",    32'(busy_a),       32'd0);
    check_eq("rst_if_rdy",  32'(ifa.if_ready), 32'd0);
    check_eq("rst_d_rdy",   32'(ifa.d_ready),  32'd0);
    check_eq("rst_if_rdat", ifa.if_rdata,      32'd0);

    // Test 1: fetch read, latency 4
    @(negedge clk);
    ifa.if_req = 1'b1; ifa.if_addr = 32'h40; ifa.mem_rdata = 32'h1234ABCD;
    en_cnt = 0; rdy_cnt = 0; rdy_at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ifa.mem_en) en_cnt++;
      if (ifa.if_ready) begin rdy_cnt++; if (rdy_at == 0) rdy_at = i; end
      if (i == 1) begin
        check_eq("t1_addr", ifa.mem_addr, 32'h40);
        check_eq("t1_we",   32'(ifa.mem_we), 32'd0);
        check_eq("t1_busy", 32'(busy_a), 32'd1);
        ifa.if_req = 1'b0;
      end
      if (i == 5) check_eq("t1_busy_idle", 32'(busy_a), 32'd0);
    end
    check_eq("t1_en_cycles", 32'(en_cnt),  32'd4);
    check_eq("t1_rdy_at",    32'(rdy_at),  32'd5);
    check_eq("t1_rdy_cnt",   32'(rdy_cnt), 32'd1);
    check_eq("t1_rdata",     ifa.if_rdata, 32'h1234ABCD);

    // Test 2: data write; inputs disturbed mid-access
    ifa.d_req = 1'b1; ifa.d_we = 1'b1; ifa.d_addr = 32'h100;
    ifa.d_wdata = 32'hDEADBEEF; ifa.mem_rdata = 32'h55555555;
    we_cnt = 0; rdy_cnt = 0; rdy_at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ifa.mem_we) we_cnt++;
      if (ifa.d_ready) begin rdy_cnt++; if (rdy_at == 0) rdy_at = i; end
      if (i == 1) begin
        check_eq("t2_addr", ifa.mem_addr, 32'h100);
        ifa.d_req = 1'b0; ifa.d_wdata = 32'h0; ifa.d_addr = 32'h0;
      end
      if (i == 4) check_eq("t2_wdata_held", ifa.mem_wdata, 32'hDEADBEEF);
    end
    check_eq("t2_we_cycles", 32'(we_cnt),  32'd4);
    check_eq("t2_rdy_at",    32'(rdy_at),  32'd5);
    check_eq("t2_rdy_cnt",   32'(rdy_cnt), 32'd1);
    check_eq("t2_rdata",     ifa.d_rdata,  32'd0);
    ifa.d_we = 1'b0;

    // Test 3: both held -> alternation, one idle cycle between accesses
    ifa.if_req = 1'b1; ifa.if_addr = 32'h80;
    ifa.d_req  = 1'b1; ifa.d_addr  = 32'h200; ifa.mem_rdata = 32'hCAFE0001;
    nev = 0; idle_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (!ifa.mem_en) idle_cnt++;
      if (ifa.d_ready && nev < 8)  begin ev_cyc[nev] = i; ev_port[nev] = 0; nev++; end
      if (ifa.if_ready && nev < 8) begin ev_cyc[nev] = i; ev_port[nev] = 1; nev++; end
      if (i == 30) begin ifa.if_req = 1'b0; ifa.d_req = 1'b0; end
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_port = 1;
`else
    first_port = 0;
`endif
    check_eq("t3_nev",  32'(nev),      32'd6);
    check_eq("t3_idle", 32'(idle_cnt), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < nev) begin
        check_eq($sformatf("t3_cyc%0d", k),  32'(ev_cyc[k]),  32'(5 * (k + 1)));
        check_eq($sformatf("t3_port%0d", k), 32'(ev_port[k]), 32'(first_port ^ (k % 2)));
      end
    end
    check_eq("t3_d_rdata",  ifa.d_rdata,  32'hCAFE0001);
    check_eq("t3_if_rdata", ifa.if_rdata, 32'hCAFE0001);

    // Test 4: reset in the 2nd busy cycle aborts the access
    @(negedge clk);
    ifa.if_req = 1'b1; ifa.if_addr = 32'h44; ifa.mem_rdata = 32'h77;
    @(negedge clk);
    ifa.if_req = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check_eq("t4_mem_en",   32'(ifa.mem_en),   32'd0);
    check_eq("t4_mem_addr", ifa.mem_addr,      32'd0);
    check_eq("t4_busy",     32'(busy_a),       32'd0);
    check_eq("t4_if_rdata", ifa.if_rdata,      32'd0);
    check_eq("t4_d_rdata",  ifa.d_rdata,       32'd0);
    rdy_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ifa.if_ready || ifa.d_ready) rdy_cnt++;
    end
    check_eq("t4_no_ready", 32'(rdy_cnt), 32'd0);

    // Test 5: halted mid-access with both reqs held
    ifa.if_req = 1'b1; ifa.if_addr = 32'h84;
    ifa.d_req  = 1'b1; ifa.d_addr  = 32'h204; ifa.mem_rdata = 32'h99;
    en_cnt = 0; rdy_cnt = 0; rdy_at = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (ifa.mem_en) en_cnt++;
      if (ifa.if_ready || ifa.d_ready) begin rdy_cnt++; if (rdy_at == 0) rdy_at = i; end
      if (i == 2) halted = 1'b1;
    end
    check_eq("t5_en_cycles", 32'(en_cnt),  32'd4);
    check_eq("t5_rdy_at",    32'(rdy_at),  32'd5);
    check_eq("t5_rdy_cnt",   32'(rdy_cnt), 32'd1);
    ifa.if_req = 1'b0; ifa.d_req = 1'b0;
    halted = 1'b0;

    // Test 6: latency 1, fetch req held continuously
    @(negedge clk);
    ifb.if_req = 1'b1; ifb.if_addr = 32'h10; ifb.mem_rdata = 32'h600D;
    nev = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ifb.if_ready && nev < 8) begin ev_cyc[nev] = i; nev++; end
    end
    ifb.if_req = 1'b0;
    check_eq("t6_nev", 32'(nev), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < nev) check_eq($sformatf("t6_cyc%0d", k), 32'(ev_cyc[k]), 32'(2 + 3 * k));
    end
    check_eq("t6_rdata", ifb.if_rdata, 32'h600D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
